// File: rtl/sram_packet_fifo_if.sv
// Packet FIFO bus: write side (framing flags + data) and pop side
// (request, registered data/flags with one-cycle strobe).
//   slave  : FIFO view (takes writes/pops, drives ready/overflow/read data)
//   master : producer/consumer view (the opposite directions)
interface sram_packet_fifo_if #(
  parameter int fifo_data_width = 16
);
  logic                       wr_sop;
  logic                       wr_eop;
  logic                       wr_vld;
  logic [fifo_data_width-1:0] wr_data;
  logic                       next_data;
  logic                       ready;
  logic                       overflow;
  logic                       sop;
  logic                       eop;
  logic                       vld;
  logic [fifo_data_width-1:0] out_data;

  modport slave (
    input  wr_sop, wr_eop, wr_vld, wr_data, next_data,
    output ready, overflow, sop, eop, vld, out_data
  );

  modport master (
    output wr_sop, wr_eop, wr_vld, wr_data, next_data,
    input  ready, overflow, sop, eop, vld, out_data
  );
endinterface

// File: rtl/sram_packet_fifo.sv
// Packet-aware single-clock FIFO in front of the SRAM controller.
// Each entry stores {data, sop, eop}; words pop as soon as stored.
// Ports:
//   clk  - sole clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - sram_packet_fifo_if.slave (write side, pop side, status)
module sram_packet_fifo #(
  parameter int fifo_data_width      = 16,
  parameter int fifo_num_of_priority = 8,   // carried for integration only
  parameter int fifo_length          = 32   // power of 2, >= 2
) (
  input  logic                     clk,
  input  logic                     rst,
  sram_packet_fifo_if.slave        bus
);
  localparam int AW = $clog2(fifo_length);
  localparam int EW = fifo_data_width + 2;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(fifo_length);

  logic [EW-1:0]              mem_q [fifo_length];
  logic [AW-1:0]              wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]                cnt_q, cnt_d;
  logic                       psop_q, psop_d;
  logic                       vld_q, sop_q, sop_d, eop_q, eop_d, ovf_q, ovf_d;
  logic [fifo_data_width-1:0] data_q, data_d;
  logic                       full, pop, wr_ok;

  assign full  = (cnt_q == FULL_CNT);
  assign pop   = bus.next_data && (cnt_q != '0);
  // A same-cycle pop frees the slot the write lands in.
  assign wr_ok = bus.wr_vld && (!full || pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    psop_d = psop_q;
    data_d = data_q;
    sop_d  = sop_q;
    eop_d  = eop_q;
    ovf_d  = bus.wr_vld && !wr_ok;
    if (wr_ok) begin
      wptr_d = wptr_q + 1'b1;
      psop_d = 1'b0;
    end else if (bus.wr_sop && !bus.wr_vld) begin
      // sop seen ahead of its first word: hold it for the next write
      psop_d = 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
      {data_d, sop_d, eop_d} = mem_q[rptr_q];
    end
    case ({wr_ok, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage is not reset; pointers/count define what is valid.
  // When full, write and pop hit the same slot; the pop reads the old entry.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wptr_q] <= {bus.wr_data, bus.wr_sop | psop_q, bus.wr_eop};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      psop_q <= 1'b0;
      vld_q  <= 1'b0;
      sop_q  <= 1'b0;
      eop_q  <= 1'b0;
      ovf_q  <= 1'b0;
      data_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      psop_q <= psop_d;
      vld_q  <= pop;
      sop_q  <= sop_d;
      eop_q  <= eop_d;
      ovf_q  <= ovf_d;
      data_q <= data_d;
    end
  end

  assign bus.ready    = rst && !full;
  assign bus.overflow = ovf_q;
  assign bus.vld      = vld_q;
  assign bus.sop      = sop_q;
  assign bus.eop      = eop_q;
  assign bus.out_data = data_q;
endmodule

// File: tb/tb_sram_packet_fifo.sv
// Randomized bench for sram_packet_fifo against a queue-based packet FIFO model.
module tb_sram_packet_fifo;
  localparam int W = 16;
  localparam int L = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sram_packet_fifo_if #(.fifo_data_width(W)) bus();

  sram_packet_fifo #(
    .fifo_data_width(W), .fifo_num_of_priority(8), .fifo_length(L)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // Model: queue of {data, sop, eop}, pending-sop bit, expected read side.
  logic [W+1:0] q[$];
  logic         m_psop;
  logic         exp_vld, exp_sop, exp_eop, exp_ovf;
  logic [W-1:0] exp_data;

  task automatic idle_inputs();
    bus.wr_sop = 0; bus.wr_eop = 0; bus.wr_vld = 0; bus.wr_data = '0; bus.next_data = 0;
  endtask

  task automatic model_clear();
    q.delete(); m_psop = 0;
    exp_vld = 0; exp_sop = 0; exp_eop = 0; exp_ovf = 0; exp_data = '0;
  endtask

  // Drive one clock of stimulus, advance model; returns at posedge+1.
  task automatic cycle(input logic v, input logic s, input logic e,
                       input logic [W-1:0] d, input logic nd);
    bit popping, accept;
    logic [W+1:0] ent;
    bus.wr_vld = v; bus.wr_sop = s; bus.wr_eop = e; bus.wr_data = d; bus.next_data = nd;
    popping = nd && (q.size() > 0);
    accept  = v && ((q.size() < L) || popping);
    exp_ovf = v && !accept;
    @(posedge clk); #1;
    if (popping) begin
      ent = q.pop_front();
      {exp_data, exp_sop, exp_eop} = ent;
      exp_vld = 1;
    end else exp_vld = 0;
    if (accept) begin
      q.push_back({d, s | m_psop, e});
      m_psop = 0;
    end else if (!v && s) m_psop = 1;
    idle_inputs();
  endtask

  task automatic test_reset();
    rst = 0; idle_inputs(); model_clear();
    #12;
    checks++;
    if ({bus.vld, bus.sop, bus.eop, bus.overflow, bus.ready, bus.out_data} !== '0)
      $display("FAIL reset_outputs: got vld=%b sop=%b eop=%b ovf=%b rdy=%b data=%h expected all 0",
               bus.vld, bus.sop, bus.eop, bus.overflow, bus.ready, bus.out_data);
    @(negedge clk) rst = 1;
    @(posedge clk); #1;
    checks++;
    if (bus.ready !== 1'b1 || bus.vld !== 1'b0) begin
      errors++; $display("FAIL reset_release: got rdy=%b vld=%b expected rdy=1 vld=0", bus.ready, bus.vld);
    end
    // traffic, then reset in mid-cycle
    cycle(1, 1, 0, 16'hA001, 0);
    cycle(1, 0, 0, 16'hA002, 0);
    cycle(1, 0, 1, 16'hA003, 1);
    checks++;
    if (bus.vld !== 1'b1 || bus.out_data !== 16'hA001 || bus.sop !== 1'b1) begin
      errors++; $display("FAIL reset_pre_traffic: got vld=%b data=%h sop=%b expected 1 a001 1", bus.vld, bus.out_data, bus.sop);
    end
    #2 rst = 0;
    #1;
    checks++;
    if ({bus.vld, bus.sop, bus.eop, bus.overflow, bus.ready, bus.out_data} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got vld=%b sop=%b eop=%b ovf=%b rdy=%b data=%h expected all 0",
               bus.vld, bus.sop, bus.eop, bus.overflow, bus.ready, bus.out_data);
    end
    model_clear();
    @(negedge clk) rst = 1;
    @(posedge clk); #1;
    checks++;
    if (bus.ready !== 1'b1 || bus.vld !== 1'b0) begin
      errors++; $display("FAIL reset_mid_release: got rdy=%b vld=%b expected rdy=1 vld=0", bus.ready, bus.vld);
    end
    cycle(0, 0, 0, '0, 1);
    checks++;
    if (bus.vld !== 1'b0) begin
      errors++; $display("FAIL reset_discard: got vld=%b expected 0 (contents discarded)", bus.vld);
    end
  endtask

  task automatic test_single_packet();
    logic [W-1:0] words [3];
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
    cycle(0, 1, 0, '0, 0);
    cycle(1, 0, 0, words[0], 0);
    cycle(1, 0, 0, words[1], 0);
    cycle(1, 0, 1, words[2], 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, '0, 1);
      checks++;
      if (bus.vld !== 1'b1 || bus.out_data !== words[i] ||
          bus.sop !== (i == 0) || bus.eop !== (i == 2)) begin
        errors++;
        $display("FAIL single_pkt[%0d]: got vld=%b data=%h sop=%b eop=%b expected 1 %h %b %b",
                 i, bus.vld, bus.out_data, bus.sop, bus.eop, words[i], i == 0, i == 2);
      end
    end
    cycle(0, 0, 0, '0, 0);
    checks++;
    if (bus.vld !== 1'b0) begin
      errors++; $display("FAIL single_pkt_strobe: got vld=%b expected 0", bus.vld);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < L; i++) begin
      checks++;
      if (bus.ready !== 1'b1) begin
        errors++; $display("FAIL fill_ready[%0d]: got %b expected 1", i, bus.ready);
      end
      cycle(1, i == 0, i == L-1, W'($urandom), 0);
    end
    checks++;
    if (bus.ready !== 1'b0) begin
      errors++; $display("FAIL fill_full_ready: got %b expected 0", bus.ready);
    end
    cycle(1, 1, 1, 16'hDEAD, 0);
    checks++;
    if (bus.overflow !== 1'b1 || exp_ovf !== 1'b1) begin
      errors++; $display("FAIL overflow_pulse: got %b expected 1", bus.overflow);
    end
    cycle(0, 0, 0, '0, 0);
    checks++;
    if (bus.overflow !== 1'b0) begin
      errors++; $display("FAIL overflow_one_cycle: got %b expected 0", bus.overflow);
    end
    for (int i = 0; i < L; i++) begin
      cycle(0, 0, 0, '0, 1);
      checks++;
      if (bus.vld !== 1'b1 || {bus.out_data, bus.sop, bus.eop} !== {exp_data, exp_sop, exp_eop}) begin
        errors++;
        $display("FAIL fill_readback[%0d]: got vld=%b %h/%b/%b expected 1 %h/%b/%b",
                 i, bus.vld, bus.out_data, bus.sop, bus.eop, exp_data, exp_sop, exp_eop);
      end
    end
    cycle(0, 0, 0, '0, 0);
    checks++;
    if (bus.vld !== 1'b0 || bus.ready !== 1'b1) begin
      errors++; $display("FAIL fill_drained: got vld=%b rdy=%b expected 0 1", bus.vld, bus.ready);
    end
  endtask

  task automatic test_wraparound();
    int written = 0;
    int guard = 0;
    logic v, nd;
    while ((written < 80 || q.size() > 0) && guard < 2000) begin
      guard++;
      v  = (written < 80) && ($urandom_range(0, 1) == 1);
      nd = ($urandom_range(0, 2) != 0);
      cycle(v, 1'($urandom), 1'($urandom), W'($urandom), nd);
      if (v && !exp_ovf) written++;
      checks++;
      if (bus.overflow !== 1'b0 || bus.vld !== exp_vld ||
          (exp_vld && {bus.out_data, bus.sop, bus.eop} !== {exp_data, exp_sop, exp_eop})) begin
        errors++;
        $display("FAIL wrap[%0d]: got ovf=%b vld=%b %h/%b/%b expected 0 %b %h/%b/%b",
                 guard, bus.overflow, bus.vld, bus.out_data, bus.sop, bus.eop,
                 exp_vld, exp_data, exp_sop, exp_eop);
      end
    end
    checks++;
    if (guard >= 2000) begin
      errors++; $display("FAIL wrap_timeout: got %0d words written expected 80 and drain", written);
    end
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < L; i++) cycle(1, 0, 0, W'($urandom), 0);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 0, W'($urandom), 1);
      checks++;
      if (bus.vld !== 1'b1 || bus.out_data !== exp_data || bus.overflow !== 1'b0 || bus.ready !== 1'b0) begin
        errors++;
        $display("FAIL full_simul[%0d]: got vld=%b data=%h ovf=%b rdy=%b expected 1 %h 0 0",
                 i, bus.vld, bus.out_data, bus.overflow, bus.ready, exp_data);
      end
    end
    for (int i = 0; i < L; i++) begin
      cycle(0, 0, 0, '0, 1);
      checks++;
      if (bus.vld !== 1'b1 || bus.out_data !== exp_data) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got vld=%b data=%h expected 1 %h", i, bus.vld, bus.out_data, exp_data);
      end
    end
  endtask

  task automatic test_empty_pop();
    cycle(1, 1, 1, 16'hABCD, 1);
    checks++;
    if (bus.vld !== 1'b0) begin
      errors++; $display("FAIL empty_wr_pop: got vld=%b expected 0", bus.vld);
    end
    cycle(0, 0, 0, '0, 1);
    checks++;
    if (bus.vld !== 1'b1 || bus.out_data !== 16'hABCD || bus.sop !== 1'b1 || bus.eop !== 1'b1) begin
      errors++;
      $display("FAIL empty_wr_readback: got vld=%b %h/%b/%b expected 1 abcd/1/1",
               bus.vld, bus.out_data, bus.sop, bus.eop);
    end
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, '0, 1);
      checks++;
      if (bus.vld !== 1'b0 || bus.out_data !== 16'hABCD || bus.sop !== 1'b1 || bus.eop !== 1'b1) begin
        errors++;
        $display("FAIL empty_pop[%0d]: got vld=%b %h/%b/%b expected 0 abcd/1/1",
                 i, bus.vld, bus.out_data, bus.sop, bus.eop);
      end
    end
  endtask

  initial begin
    idle_inputs();
    model_clear();
    test_reset();
    test_single_packet();
    test_fill_overflow();
    test_wraparound();
    test_full_simul();
    test_empty_pop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sram_packet_fifo.md
# sram_packet_fifo

Single-clock packet-aware FIFO buffering words from the packet ingress port ahead of the SRAM controller. Writes are qualified per clock by `wr_vld`; `wr_sop`/`wr_eop` framing flags are stored with each word and replayed on the read side. Reads are pop-on-request via `next_data`, with registered output data and a one-cycle `vld` strobe. Overflow drops the word and is flagged.

## Interface
- `fifo_data_width`, 16, width of stored/returned data word
- `fifo_num_of_priority`, 8, priority-class count carried for integration; no functional effect in this block
- `fifo_length`, 32, depth in words; must be a power of 2, ≥2
- `clk`  input  1  sole clock; all state updates on rising edge
- `rst`  input  1  asynchronous, active-low reset
- `wr_sop`  input  1  start-of-packet mark; may arrive with or without `wr_vld`
- `wr_eop`  input  1  end-of-packet mark; sampled only with `wr_vld`
- `wr_vld`  input  1  write strobe; one word per cycle high
- `wr_data`  input  fifo_data_width  write word
- `next_data`  input  1  pop request; one word per cycle high
- `ready`  output  1  write side can accept a word this cycle
- `overflow`  output  1  registered one-cycle pulse: a write was dropped
- `sop`  output  1  start flag of popped word
- `eop`  output  1  end flag of popped word
- `vld`  output  1  `out_data`/`sop`/`eop` valid this cycle
- `out_data`  output  fifo_data_width  popped word

## Operation
- Storage: `fifo_length` entries of `fifo_data_width+2` bits (data, sop flag, eop flag).
- Write pointer, read pointer: log2(`fifo_length`) bits, wrap modulo depth. Occupancy count: log2(`fifo_length`)+1 bits, range 0..`fifo_length`.
- Pending-sop latch: set by `wr_sop` on a cycle without `wr_vld`; cleared when the next word is written. Stored sop flag = `wr_sop | pending_sop` at the write.
- Stored eop flag = `wr_eop` at the write.
- Write accepted when `wr_vld` and (count < `fifo_length` or a pop occurs same cycle).
- Write attempted when full and no same-cycle pop: word dropped, pending-sop unchanged, pointers/count unchanged, `overflow` = 1 next cycle.
- Pop occurs when `next_data` and count > 0: entry at read pointer loaded into `out_data`/`sop`/`eop`, `vld` = 1 next cycle, read pointer increments.
- `next_data` while empty: no pop, `vld` = 0, `out_data`/`sop`/`eop` hold last values.
- Count: +1 write only, −1 pop only, unchanged on both or neither.
- `ready` = `rst` & (count < `fifo_length`), combinational.
- No packet-completeness gating: words pop as soon as stored (cut-through).

## Timing
- Reset (`rst` low, async): pointers, count, pending-sop = 0; `vld`, `sop`, `eop`, `overflow` = 0; `out_data` = 0; `ready` = 0 while asserted, 1 after release (empty).
- Write at edge N is poppable by a `next_data` sampled at edge N+1 (earliest `vld` after edge N+1).
- Pop latency: `next_data` sampled at edge N → `vld`/data after edge N; `vld` high exactly one cycle per pop.
- Continuous `next_data` with data available: one word per cycle, back-to-back `vld`.
- Full + simultaneous write and pop: both succeed, count stays `fifo_length`.
- Empty + simultaneous write and pop: no pop (count 0 at sample); write stored.
- Reset mid-operation: contents discarded, outputs to reset values immediately.

## Test plan
- Reset: drive `rst` low mid-traffic → all outputs 0, `ready` 0; release → `ready` 1, `vld` 0.
- Single packet: `wr_sop` pulse alone, then 3 words 0x1111,0x2222,0x3333 (last with `wr_eop`), then `next_data` 3 cycles → `vld` 3 cycles, data in order, `sop` only on 0x1111, `eop` only on 0x3333.
- Fill: 32 writes without pop → `ready` 0 after 32nd; 33rd write → `overflow` pulse 1 cycle, word absent on readback; 32 pops return original 32 words.
- Wrap-around: write/pop interleaved 80 words of random data → output sequence matches input exactly, no `overflow`.
- Full with simultaneous write+pop → both succeed, `ready` stays 0, no `overflow`.
- Empty pop: `next_data` high 10 cycles on empty FIFO → `vld` stays 0, `out_data` unchanged.
